// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared TDM constants and state type for the mux/demux pair
package tdm_pkg;

  localparam int LANES = 8;
  localparam int SEL_W = $clog2(LANES);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } tdm_state_e;

  localparam logic [SEL_W-1:0] TDM_SLOT0 = '0;

endpackage

// File: rtl/tdm_slot_counter.sv
// rtl/tdm_slot_counter.sv - mod-LANES slot counter with enable and load-to-1
module tdm_slot_counter #(
  parameter int LANES = tdm_pkg::LANES,
  parameter int SEL_W = tdm_pkg::SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_load1,
  output logic [SEL_W-1:0] o_count
);
  import tdm_pkg::TDM_SLOT0;

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(LANES - 1);

  logic [SEL_W-1:0] r_count;

  // Load-to-1 wins: a sync bit occupies slot 0 in the same cycle it is seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= TDM_SLOT0;
    end else if (i_load1) begin
      r_count <= SEL_W'(1);
    end else if (i_en) begin
      r_count <= (r_count == LAST_SLOT) ? TDM_SLOT0 : r_count + SEL_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/tdm_demux_8.sv
// rtl/tdm_demux_8.sv - eight-channel TDM demultiplexer with frame_sync lock
module tdm_demux_8 #(
  parameter int LANES = tdm_pkg::LANES,
  parameter int SEL_W = tdm_pkg::SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             frame_sync,
  output logic [LANES-1:0] out_data,
  output logic             out_valid,
  output logic [SEL_W-1:0] slot,
  output logic             locked,
  output logic             sync_err
);
  import tdm_pkg::tdm_state_e;
  import tdm_pkg::HUNT;
  import tdm_pkg::LOCKED;
  import tdm_pkg::TDM_SLOT0;

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(LANES - 1);

  tdm_state_e       r_state;
  tdm_state_e       w_state_next;
  logic [LANES-1:0] r_shadow;
  logic [LANES-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_sync_err;
  logic [SEL_W-1:0] w_slot;
  logic [SEL_W-1:0] w_wr_idx;
  logic             w_sync;
  logic             w_in_lock;
  logic             w_store;
  logic             w_cnt_en;
  logic             w_complete;
  logic             w_resync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (r_state == HUNT && w_sync) begin
      w_state_next = LOCKED;
    end
  end

  always_comb begin
    w_sync     = in_valid & frame_sync;
    w_in_lock  = (r_state == LOCKED);
    w_store    = w_sync | (in_valid & w_in_lock);
    w_cnt_en   = in_valid & w_in_lock;
    w_wr_idx   = w_sync ? TDM_SLOT0 : w_slot;
    // A sync at slot 7 is a resync, so it must not also complete the frame.
    w_complete = in_valid & w_in_lock & ~frame_sync & (w_slot == LAST_SLOT);
    w_resync   = w_sync & w_in_lock & (w_slot != TDM_SLOT0);
  end

  tdm_slot_counter #(
    .LANES (LANES),
    .SEL_W (SEL_W)
  ) u_slot_counter (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_cnt_en),
    .i_load1 (w_sync),
    .o_count (w_slot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
    end else if (w_store) begin
      r_shadow[w_wr_idx] <= in_bit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      r_out_valid <= w_complete;
      r_sync_err  <= w_resync;
      if (w_complete) begin
        r_out_data <= {in_bit, r_shadow[LANES-2:0]};
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign sync_err  = r_sync_err;
  assign slot      = w_slot;
  assign locked    = w_in_lock;

endmodule
